// File: rtl/seg_pkg.sv
// seg_pkg: shared state type, blank pattern and hex-to-segment table for the scan controller.
package seg_pkg;

    typedef enum logic [1:0] {ST_IDLE, ST_GAP, ST_SHOW} state_t;

    localparam logic [7:0] SEG_OFF = 8'hFF;

    // Active-low a..g in bits 7..1, dp (bit 0) off, for hex 0..F
    localparam logic [7:0] SEG_TABLE [16] = '{
        8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F,
        8'h01, 8'h09, 8'h11, 8'hC1, 8'h63, 8'h85, 8'h61, 8'h71
    };

endpackage

// File: rtl/seg_hex_dec.sv
// seg_hex_dec: combinational hex nibble to active-low 7-segment pattern, dp bit held off.
module seg_hex_dec
    import seg_pkg::*;
(
    input  logic [3:0] nib,
    output logic [7:0] seg
);

    assign seg = SEG_TABLE[nib];

endmodule

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: multiplexed 7-segment scanner with frame-aligned value commit,
// per-digit dwell and an all-off gap before each digit to avoid ghosting.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int NDIG  = 8,
    parameter int DWELL = 1000,
    parameter int GAP   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              val_valid,
    output logic              val_ready,
    input  logic [4*NDIG-1:0] val_data,
    input  logic [NDIG-1:0]   val_dp,
    input  logic [NDIG-1:0]   val_blank,
    output logic [7:0]        seg_n,
    output logic [NDIG-1:0]   an_n,
    output logic              frame_start
);

    localparam int PW = $clog2((GAP > DWELL ? GAP : DWELL) + 1);
    localparam int IW = $clog2(NDIG);

    state_t            state, state_nx;
    logic [IW-1:0]     idx, idx_nx;
    logic [PW-1:0]     ph, ph_nx;
    logic [4*NDIG-1:0] disp_data, disp_data_nx, pend_data;
    logic [NDIG-1:0]   disp_dp, disp_dp_nx, pend_dp;
    logic [NDIG-1:0]   disp_blank, disp_blank_nx, pend_blank;
    logic              pend_full, accept, commit, enter0, lit;
    logic [7:0]        dec, seg_nx;
    logic [NDIG-1:0]   an_nx;
    logic              frame_nx;

    assign val_ready = !pend_full;
    assign accept    = val_valid && !pend_full;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            idx         <= '0;
            ph          <= '0;
            disp_data   <= '0;
            disp_dp     <= '0;
            disp_blank  <= '1;
            pend_data   <= '0;
            pend_dp     <= '0;
            pend_blank  <= '0;
            pend_full   <= 1'b0;
            seg_n       <= SEG_OFF;
            an_n        <= '1;
            frame_start <= 1'b0;
        end else begin
            state       <= state_nx;
            idx         <= idx_nx;
            ph          <= ph_nx;
            disp_data   <= disp_data_nx;
            disp_dp     <= disp_dp_nx;
            disp_blank  <= disp_blank_nx;
            pend_full   <= accept ? 1'b1 : commit ? 1'b0 : pend_full;
            seg_n       <= seg_nx;
            an_n        <= an_nx;
            frame_start <= frame_nx;
            if (accept) begin
                pend_data  <= val_data;
                pend_dp    <= val_dp;
                pend_blank <= val_blank;
            end
        end
    end

    always_comb begin
        state_nx = state;
        idx_nx   = idx;
        ph_nx    = ph + 1'b1;
        if (!en) begin
            state_nx = ST_IDLE;
            idx_nx   = '0;
            ph_nx    = '0;
        end else if (state == ST_IDLE) begin
            state_nx = ST_GAP;
            idx_nx   = '0;
            ph_nx    = '0;
        end else if (state == ST_GAP && ph == PW'(GAP - 1)) begin
            state_nx = ST_SHOW;
            ph_nx    = '0;
        end else if (state == ST_SHOW && ph == PW'(DWELL - 1)) begin
            state_nx = ST_GAP;
            idx_nx   = (idx == IW'(NDIG - 1)) ? '0 : idx + 1'b1;
            ph_nx    = '0;
        end
    end

    // Outputs are registered from next-state values so they line up with the state they describe
    assign enter0        = state_nx == ST_GAP && state != ST_GAP && idx_nx == '0;
    assign commit        = pend_full && (enter0 || state == ST_IDLE);
    assign disp_data_nx  = commit ? pend_data : disp_data;
    assign disp_dp_nx    = commit ? pend_dp : disp_dp;
    assign disp_blank_nx = commit ? pend_blank : disp_blank;

    seg_hex_dec u_dec (
        .nib (disp_data_nx[idx_nx*4 +: 4]),
        .seg (dec)
    );

    always_comb begin
        lit      = state_nx == ST_SHOW && !disp_blank_nx[idx_nx];
        an_nx    = lit ? ~(NDIG'(1) << idx_nx) : '1;
        seg_nx   = lit ? {dec[7:1], ~disp_dp_nx[idx_nx]} : SEG_OFF;
        frame_nx = enter0;
    end

endmodule
